// File: rtl/case_decoder_pkg.sv
// -----------------------------------------------------------------------------
// case_decoder_pkg
//   Shared constants for the programmable case decoder.
//   MODE_PRIORITY : lowest-index matching entry supplies the output mask.
//   MODE_OR       : output mask is the bitwise OR of every matching entry.
//   The {en, code, mask} table-entry record depends on IN_W/OUT_W.
//   It is therefore declared as entry_t inside case_decoder_entry, where
//   those widths are known.
// -----------------------------------------------------------------------------
package case_decoder_pkg;

   localparam int MODE_PRIORITY = 0;
   localparam int MODE_OR       = 1;

endpackage

// File: rtl/case_decoder_entry.sv
// -----------------------------------------------------------------------------
// case_decoder_entry
//   One match-table entry {en, code, mask} plus its saturating hit counter.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     wr_i        write strobe already decoded for this entry
//     wr_en_i     valid bit to store
//     wr_code_i   code to store
//     wr_mask_i   mask to store
//     code_i      lookup code
//     inc_i       count one hit this cycle
//     match_o     entry is valid and its code equals code_i
//     mask_o      stored mask
//     cnt_o       hit counter value
// -----------------------------------------------------------------------------
module case_decoder_entry #(
   parameter int IN_W  = 3,
   parameter int OUT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic             wr_en_i,
   input  logic [IN_W-1:0]  wr_code_i,
   input  logic [OUT_W-1:0] wr_mask_i,
   input  logic [IN_W-1:0]  code_i,
   input  logic             inc_i,
   output logic             match_o,
   output logic [OUT_W-1:0] mask_o,
   output logic [CNT_W-1:0] cnt_o
);

   typedef struct packed {
      logic             en;
      logic [IN_W-1:0]  code;
      logic [OUT_W-1:0] mask;
   } entry_t;

   entry_t           entry_q, entry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      entry_d = entry_q;
      cnt_d   = cnt_q;
      if (wr_i) begin
         entry_d.en   = wr_en_i;
         entry_d.code = wr_code_i;
         entry_d.mask = wr_mask_i;
         // A rewrite restarts the statistics, even if the old entry hit this cycle.
         cnt_d        = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
         cnt_q   <= '0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
      end
   end

   // Compare against the registered table, so a same-cycle write is not yet visible.
   assign match_o = entry_q.en && (entry_q.code == code_i);
   assign mask_o  = entry_q.mask;
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/case_decoder_pipe.sv
// -----------------------------------------------------------------------------
// case_decoder_pipe
//   Programmable code-to-mask decoder with a registered valid/ready output.
//   The table has ENTRIES run-time loadable entries, each with a hit counter.
//   Ports:
//     clk, rst                         clock, asynchronous active-high reset
//     cfg_we/idx/en/code/mask          table write port (idx >= ENTRIES ignored)
//     in_valid, in_code, in_ready      input handshake
//     out_valid, out_ready             output handshake
//     out_y, out_hit, out_idx          decoded mask, hit flag, lowest match index
//     cnt_idx, cnt_val                 combinational hit-counter read
// -----------------------------------------------------------------------------
module case_decoder_pipe
   import case_decoder_pkg::*;
#(
   parameter int               IN_W      = 3,
   parameter int               OUT_W     = 4,
   parameter int               ENTRIES   = 4,
   parameter int               MODE      = MODE_PRIORITY,
   parameter logic [OUT_W-1:0] DEFAULT_Y = '0,
   parameter int               CNT_W     = 8,
   localparam int              IDX_W     = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic             cfg_en,
   input  logic [IN_W-1:0]  cfg_code,
   input  logic [OUT_W-1:0] cfg_mask,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_code,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_y,
   output logic             out_hit,
   output logic [IDX_W-1:0] out_idx,
   input  logic [IDX_W-1:0] cnt_idx,
   output logic [CNT_W-1:0] cnt_val
);

   logic [ENTRIES-1:0] match;
   logic [ENTRIES-1:0] cnt_inc;
   logic [ENTRIES-1:0] win_onehot;
   logic [OUT_W-1:0]   mask_arr [ENTRIES];
   logic [CNT_W-1:0]   cnt_arr  [ENTRIES];

   logic               accept;
   logic               hit;
   logic               found;
   logic [IDX_W-1:0]   win_idx;
   logic [OUT_W-1:0]   win_mask;
   logic [OUT_W-1:0]   or_mask;
   logic [OUT_W-1:0]   y_sel;

   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_y_q, out_y_d;
   logic               out_hit_q, out_hit_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Entry index decode: indices >= ENTRIES match no entry, so those writes fall away.
   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
         case_decoder_entry #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .CNT_W (CNT_W)
         ) u_entry (
            .clk       (clk),
            .rst       (rst),
            .wr_i      (cfg_we && (cfg_idx == IDX_W'(gi))),
            .wr_en_i   (cfg_en),
            .wr_code_i (cfg_code),
            .wr_mask_i (cfg_mask),
            .code_i    (in_code),
            .inc_i     (cnt_inc[gi]),
            .match_o   (match[gi]),
            .mask_o    (mask_arr[gi]),
            .cnt_o     (cnt_arr[gi])
         );
      end
   endgenerate

   // Lowest-index winner and OR of all matches are both built.
   // MODE then selects which one drives the output and the counters.
   always_comb begin
      found      = 1'b0;
      win_idx    = '0;
      win_mask   = '0;
      win_onehot = '0;
      or_mask    = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (match[i]) begin
            or_mask = or_mask | mask_arr[i];
            if (!found) begin
               found         = 1'b1;
               win_idx       = IDX_W'(i);
               win_mask      = mask_arr[i];
               win_onehot[i] = 1'b1;
            end
         end
      end
      hit = found;
      if (!hit)
         y_sel = DEFAULT_Y;
      else if (MODE == MODE_OR)
         y_sel = or_mask;
      else
         y_sel = win_mask;
      if (!accept)
         cnt_inc = '0;
      else if (MODE == MODE_OR)
         cnt_inc = match;
      else
         cnt_inc = win_onehot;
   end

   // The output stage loads whenever the consumer can make room.
   // Otherwise it holds, which keeps out_* stable while stalled.
   always_comb begin
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_hit_d   = out_hit_q;
      out_idx_d   = out_idx_q;
      if (in_ready) begin
         out_valid_d = in_valid;
         if (in_valid) begin
            out_y_d   = y_sel;
            out_hit_d = hit;
            out_idx_d = win_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_hit_q   <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_hit_q   <= out_hit_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_hit   = out_hit_q;
   assign out_idx   = out_idx_q;

   // Compare-and-select read, so a cnt_idx beyond the table reads 0 rather than out of range.
   always_comb begin
      cnt_val = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (cnt_idx == IDX_W'(i))
            cnt_val = cnt_arr[i];
      end
   end

endmodule

// File: tb/tb_case_decoder_pipe.sv
// -----------------------------------------------------------------------------
// tb_case_decoder_pipe
//   Two decoders share every input:
//     dut_p : priority mode, 4 entries, 2-bit counters, default mask 0000
//     dut_o : OR mode, 3 entries, 8-bit counters, default mask 1010
//   A reference table and counters predict each result.
//   Predictions are queued on accept and checked when the output appears.
// -----------------------------------------------------------------------------
module tb_case_decoder_pipe;
   import case_decoder_pkg::*;

   localparam int NE_O = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we, cfg_en;
   logic [1:0] cfg_idx, cnt_idx;
   logic [2:0] cfg_code, in_code;
   logic [3:0] cfg_mask;
   logic       in_valid, out_ready;

   logic       p_in_ready, p_out_valid, p_out_hit;
   logic [3:0] p_out_y;
   logic [1:0] p_out_idx, p_cnt_val;
   logic       o_in_ready, o_out_valid, o_out_hit;
   logic [3:0] o_out_y;
   logic [1:0] o_out_idx;
   logic [7:0] o_cnt_val;

   always #10 clk = ~clk;

   case_decoder_pipe #(
      .IN_W(3), .OUT_W(4), .ENTRIES(4), .MODE(MODE_PRIORITY),
      .DEFAULT_Y(4'h0), .CNT_W(2)
   ) dut_p (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
      .cfg_code(cfg_code), .cfg_mask(cfg_mask), .in_valid(in_valid), .in_code(in_code),
      .in_ready(p_in_ready), .out_valid(p_out_valid), .out_ready(out_ready),
      .out_y(p_out_y), .out_hit(p_out_hit), .out_idx(p_out_idx),
      .cnt_idx(cnt_idx), .cnt_val(p_cnt_val)
   );

   case_decoder_pipe #(
      .IN_W(3), .OUT_W(4), .ENTRIES(NE_O), .MODE(MODE_OR),
      .DEFAULT_Y(4'hA), .CNT_W(8)
   ) dut_o (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
      .cfg_code(cfg_code), .cfg_mask(cfg_mask), .in_valid(in_valid), .in_code(in_code),
      .in_ready(o_in_ready), .out_valid(o_out_valid), .out_ready(out_ready),
      .out_y(o_out_y), .out_hit(o_out_hit), .out_idx(o_out_idx),
      .cnt_idx(cnt_idx), .cnt_val(o_cnt_val)
   );

   typedef struct packed {
      logic [3:0] y;
      logic       hit;
      logic [1:0] idx;
   } res_t;

   res_t       q_p[$], q_o[$];
   res_t       last_p, last_o;
   logic       m_en   [4];
   logic [2:0] m_code [4];
   logic [3:0] m_mask [4];
   int         cnt_p  [4];
   int         cnt_o  [4];
   bit         m_ov;
   int         n_vec;
   int         n_miss;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_en[i]   = 1'b0;
         m_code[i] = 3'd0;
         m_mask[i] = 4'd0;
         cnt_p[i]  = 0;
         cnt_o[i]  = 0;
      end
      m_ov = 1'b0;
      q_p.delete();
      q_o.delete();
   endtask

   // One clock cycle.
   // Predict from the pre-write table, apply any write to the model,
   // then check the outputs after the edge.
   task automatic tick();
      res_t ep, eo;
      bit   rdy, acc;
      #1;
      rdy = !m_ov || out_ready;
      chk("in_ready_p", 32'(p_in_ready), 32'(rdy));
      chk("in_ready_o", 32'(o_in_ready), 32'(rdy));
      acc = in_valid && rdy;
      if (acc) begin
         ep = '0;
         eo = '0;
         for (int i = 0; i < 4; i++) begin
            if (m_en[i] && m_code[i] == in_code && !ep.hit) begin
               ep.hit = 1'b1;
               ep.y   = m_mask[i];
               ep.idx = 2'(i);
               if (cnt_p[i] < 3) cnt_p[i]++;
            end
         end
         for (int i = 0; i < NE_O; i++) begin
            if (m_en[i] && m_code[i] == in_code) begin
               if (!eo.hit) eo.idx = 2'(i);
               eo.hit = 1'b1;
               eo.y   = eo.y | m_mask[i];
               if (cnt_o[i] < 255) cnt_o[i]++;
            end
         end
         if (!eo.hit) eo.y = 4'hA;
         q_p.push_back(ep);
         q_o.push_back(eo);
      end
      if (cfg_we) begin
         m_en[cfg_idx]   = cfg_en;
         m_code[cfg_idx] = cfg_code;
         m_mask[cfg_idx] = cfg_mask;
         cnt_p[cfg_idx]  = 0;
         cnt_o[cfg_idx]  = 0;
      end
      if (rdy) m_ov = in_valid;
      @(posedge clk);
      #1;
      chk("out_valid_p", 32'(p_out_valid), 32'(m_ov));
      chk("out_valid_o", 32'(o_out_valid), 32'(m_ov));
      if (acc) begin
         last_p = q_p.pop_front();
         last_o = q_o.pop_front();
      end
      if (m_ov) begin
         chk("out_y_p",   32'(p_out_y),   32'(last_p.y));
         chk("out_hit_p", 32'(p_out_hit), 32'(last_p.hit));
         chk("out_idx_p", 32'(p_out_idx), 32'(last_p.idx));
         chk("out_y_o",   32'(o_out_y),   32'(last_o.y));
         chk("out_hit_o", 32'(o_out_hit), 32'(last_o.hit));
         chk("out_idx_o", 32'(o_out_idx), 32'(last_o.idx));
         $display("  txn code-result p:y=%b hit=%0d idx=%0d  o:y=%b hit=%0d idx=%0d",
                  p_out_y, p_out_hit, p_out_idx, o_out_y, o_out_hit, o_out_idx);
      end
   endtask

   task automatic cfg(input logic [1:0] idx, input logic en, input logic [2:0] code,
                      input logic [3:0] mask);
      cfg_we   = 1'b1;
      cfg_idx  = idx;
      cfg_en   = en;
      cfg_code = code;
      cfg_mask = mask;
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic send(input logic [2:0] code);
      in_valid = 1'b1;
      in_code  = code;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      tick();
   endtask

   task automatic chk_cnt(input logic [1:0] idx);
      cnt_idx = idx;
      #1;
      chk("cnt_val_p", 32'(p_cnt_val), 32'(cnt_p[idx]));
      chk("cnt_val_o", 32'(o_cnt_val), 32'(cnt_o[idx]));
   endtask

   initial begin
      n_vec     = 0;
      n_miss    = 0;
      rst       = 1'b1;
      cfg_we    = 1'b0;
      cfg_en    = 1'b0;
      cfg_idx   = 2'd0;
      cfg_code  = 3'd0;
      cfg_mask  = 4'd0;
      in_valid  = 1'b0;
      in_code   = 3'd0;
      out_ready = 1'b0;
      cnt_idx   = 2'd0;
      last_p    = '0;
      last_o    = '0;
      model_clear();

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid_p", 32'(p_out_valid), 32'd0);
      chk("rst_y_p",     32'(p_out_y),     32'd0);
      chk("rst_hit_p",   32'(p_out_hit),   32'd0);
      chk("rst_idx_p",   32'(p_out_idx),   32'd0);
      chk("rst_valid_o", 32'(o_out_valid), 32'd0);
      chk("rst_y_o",     32'(o_out_y),     32'd0);
      chk_cnt(2'd0);
      chk_cnt(2'd3);
      rst = 1'b0;

      // Legacy table with full throughput.
      out_ready = 1'b1;
      cfg(2'd0, 1'b1, 3'b000, 4'b0001);
      cfg(2'd1, 1'b1, 3'b011, 4'b0010);
      cfg(2'd2, 1'b1, 3'b101, 4'b0100);
      cfg(2'd3, 1'b1, 3'b111, 4'b0011);
      send(3'b000);
      send(3'b011);
      send(3'b101);
      send(3'b111);
      send(3'b010);
      idle();
      for (int i = 0; i < 4; i++) chk_cnt(2'(i));

      // Backpressure: hold for 5 cycles, then accept on release.
      out_ready = 1'b0;
      send(3'b011);
      in_code = 3'b101;
      repeat (5) tick();
      out_ready = 1'b1;
      tick();
      idle();

      // Same-cycle write and lookup on entry 1.
      cfg_we   = 1'b1;
      cfg_idx  = 2'd1;
      cfg_en   = 1'b1;
      cfg_code = 3'b110;
      cfg_mask = 4'b1100;
      in_valid = 1'b1;
      in_code  = 3'b011;
      tick();
      cfg_we = 1'b0;
      chk_cnt(2'd1);
      send(3'b011);
      send(3'b110);
      idle();
      chk_cnt(2'd1);

      // Duplicate codes on entries 0 and 2.
      cfg(2'd0, 1'b1, 3'b101, 4'b0001);
      cfg(2'd2, 1'b1, 3'b101, 4'b1000);
      send(3'b101);
      idle();
      chk_cnt(2'd0);
      chk_cnt(2'd2);

      // Saturation, and a rewrite clearing the counter.
      repeat (6) send(3'b111);
      repeat (6) send(3'b101);
      idle();
      chk_cnt(2'd3);
      chk_cnt(2'd0);
      chk_cnt(2'd2);
      cfg(2'd3, 1'b1, 3'b111, 4'b0011);
      chk_cnt(2'd3);
      send(3'b111);
      idle();

      // Asynchronous reset while a result is stalled.
      out_ready = 1'b0;
      send(3'b101);
      in_valid = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      chk("arst_valid_p", 32'(p_out_valid), 32'd0);
      chk("arst_y_p",     32'(p_out_y),     32'd0);
      chk("arst_hit_p",   32'(p_out_hit),   32'd0);
      chk("arst_valid_o", 32'(o_out_valid), 32'd0);
      chk("arst_y_o",     32'(o_out_y),     32'd0);
      chk("arst_rdy_p",   32'(p_in_ready),  32'd1);
      chk_cnt(2'd0);
      chk_cnt(2'd2);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(3'b101);
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
